keymgr_op_seq_guard: RTL

//  Parametrised key-manager operation-sequence guard. Keeps a shift history of the last SEQ_LEN

---
 rtl/keymgr_op_seq_guard.sv | 92 +++++++++
 1 files changed

// File: rtl/keymgr_op_seq_guard.sv
// keymgr_op_seq_guard: matches the last SEQ_LEN committed keymgr ops against a locked pattern
// and holds the key-output enables low behind a sticky alert until software clears it.
module keymgr_op_seq_guard #(
    parameter int OP_W = 3,
    parameter int SEQ_LEN = 4,
    parameter int GAP_W = 8,
    parameter int STATE_W = 10,
    parameter logic [STATE_W-1:0] OWNER_ST = 10'b1101111110
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       op_start,
    input  logic                       op_done,
    input  logic [OP_W-1:0]            op,
    input  logic                       pat_wr_en,
    input  logic [$clog2(SEQ_LEN)-1:0] pat_wr_idx,
    input  logic [OP_W-1:0]            pat_wr_data,
    input  logic                       pat_lock,
    input  logic [GAP_W-1:0]           gap_limit,
    input  logic                       alert_clr,
    input  logic [STATE_W-1:0]         cur_state,
    output logic                       data_hw_en,
    output logic                       data_sw_en,
    output logic                       data_valid,
    output logic                       alert,
    output logic                       armed,
    output logic [7:0]                 match_cnt
);
    localparam int FILL_W = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(SEQ_LEN);

    typedef enum logic [1:0] {UNCFG, TRACK, ALERT} state_t;

    state_t state_q, state_d;
    logic [OP_W-1:0] pat_q [SEQ_LEN];
    logic [OP_W-1:0] hist_q [SEQ_LEN];
    logic [OP_W-1:0] hist_d [SEQ_LEN];
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
    logic [7:0] cnt_q;
    logic en_q;
    logic commit, take, clr_now, timeout, hist_eq, match;

    always_comb begin
        commit = op_start & op_done;
        take = commit && state_q != ALERT;
        clr_now = state_q == ALERT && alert_clr;
        for (int i = 0; i < SEQ_LEN - 1; i++) hist_d[i] = take ? hist_q[i+1] : hist_q[i];
        hist_d[SEQ_LEN-1] = take ? op : hist_q[SEQ_LEN-1];
        hist_eq = 1'b1;
        for (int i = 0; i < SEQ_LEN; i++) if (hist_d[i] != pat_q[i]) hist_eq = 1'b0;
        gap_inc = (gap_q == '1) ? gap_q : gap_q + 1'b1;
        // the idle cycle whose increment lands on the limit is the one that expires the history
        timeout = !commit && gap_limit != '0 && gap_inc >= gap_limit;
        gap_d = (commit || clr_now) ? '0 : gap_inc;
        fill_d = clr_now ? '0 :
                 state_q == ALERT ? fill_q :
                 timeout ? '0 :
                 (take && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
        match = state_q == TRACK && take && fill_d == FULL && hist_eq;
        state_d = (state_q == UNCFG && pat_lock) ? TRACK :
                  match ? ALERT :
                  clr_now ? TRACK : state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNCFG;
            pat_q <= '{default: '0};
            hist_q <= '{default: '0};
            fill_q <= '0;
            gap_q <= '0;
            cnt_q <= '0;
            en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            gap_q <= gap_d;
            en_q <= cur_state == OWNER_ST && state_d != ALERT;
            if (state_q == UNCFG && pat_wr_en && 32'(pat_wr_idx) < SEQ_LEN) pat_q[pat_wr_idx] <= pat_wr_data;
            if (match && cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
        end
    end

    assign data_hw_en = en_q;
    assign data_sw_en = en_q;
    assign data_valid = en_q;
    assign alert = state_q == ALERT;
    assign armed = state_q != UNCFG;
    assign match_cnt = cnt_q;
endmodule
